// File: rtl/io_input_queue.sv
// io_input_queue: edge-triggered capture FIFO read by the CPU through a STATUS/DATA register window
// Ports: clk, rst (sync, active-high); start + y1..y4 from the capture stage (push on start rising edge);
//        rd_en/wr_en/addr/wdata CPU access (addr 0 = STATUS, 1 = DATA); rdata registered load data;
//        irq (only when IOQ_IRQ_EN is defined) = registered (count != 0 | ovf).
module io_input_queue #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        y1,
    input  logic [3:0]  y2,
    input  logic [3:0]  y3,
    input  logic [3:0]  y4,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic        addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata
`ifdef IOQ_IRQ_EN
    ,
    output logic        irq
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [12:0]   mem_q [DEPTH];
    logic          start_q, ovf_q, ovf_d;
    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   rdata_q, rdata_d, status;
    logic          push, pop, wr, flush, full, empty, acc, drop;
    logic          unused_ok;
    assign unused_ok = ^{wdata[31:3], wdata[1]};
    always_comb begin
        push    = start & ~start_q;
        wr      = wr_en & ~rd_en;
        full    = count_q == CW'(DEPTH);
        empty   = count_q == '0;
        pop     = rd_en & addr & ~empty;
        flush   = wr & ~addr & wdata[0];
        // a pop in the same cycle frees the slot a full queue would otherwise refuse
        acc     = push & ~flush & (~full | pop);
        drop    = push & ~flush & full & ~pop;
        wptr_d  = flush ? '0 : acc ? wptr_q + AW'(1) : wptr_q;
        rptr_d  = flush ? '0 : pop ? rptr_q + AW'(1) : rptr_q;
        count_d = flush ? '0 : count_q + CW'(acc) - CW'(pop);
        // a dropped push outranks a same-cycle clear
        ovf_d   = drop | (ovf_q & ~(wr & ~addr & wdata[2]));
        status  = {24'd0, 4'(count_q), 1'b0, ovf_q, full, empty};
        rdata_d = ~rd_en ? rdata_q : ~addr ? status : empty ? 32'd0 : {1'b1, 18'd0, mem_q[rptr_q]};
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            start_q <= 1'b0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            rdata_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            start_q <= start;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            rdata_q <= rdata_d;
            if (acc) mem_q[wptr_q] <= {y1, y2, y3, y4};
        end
    end
    assign rdata = rdata_q;
`ifdef IOQ_IRQ_EN
    logic irq_q;
    always_ff @(posedge clk) begin
        if (rst) irq_q <= 1'b0;
        else irq_q <= ~empty | ovf_q;
    end
    assign irq = irq_q;
`endif
endmodule

// File: doc/io_input_queue.md
# io_input_queue

Memory-mapped input queue directly downstream of the switch/button capture stage. It edge-detects that stage's `start` level, pushes the captured 13-bit word `{y1,y2,y3,y4}` into a small FIFO, and lets the RV32 core read status and pop entries through a two-register load/store window. Bursts of button presses are buffered until software drains them.

## Interface
Parameters:
- `DEPTH`, 4: FIFO entries. Power of two, 2..8.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset. Synchronous, active-high.
- `start`  in  1  level from the capture stage. High while the debounced button is held.
- `y1`  in  1  captured word bit 12.
- `y2`  in  4  captured word bits 11:8.
- `y3`  in  4  captured word bits 7:4.
- `y4`  in  4  captured word bits 3:0.
- `rd_en`  in  1  CPU load strobe, one cycle per access.
- `wr_en`  in  1  CPU store strobe, one cycle per access.
- `addr`  in  1  register select: 0 = STATUS, 1 = DATA.
- `wdata`  in  32  store data.
- `rdata`  out  32  load data, registered.
- `irq`  out  1  only with `IOQ_IRQ_EN`; see Configuration.

## Operation
- Edge detect:
  - `start_d` is `start` delayed one cycle.
  - A push event is `start & ~start_d`.
  - One event is generated per button press, however long `start` stays high.
- Push:
  - The entry is `{y1,y2,y3,y4}`, sampled on the same edge as the event.
  - Written at `wptr`; `wptr` wraps modulo `DEPTH`.
- Full:
  - A push event while `count==DEPTH` is dropped.
  - The sticky `ovf` flag is set.
- STATUS read (`rd_en`, `addr=0`) returns:
  - bit0 = empty
  - bit1 = full
  - bit2 = `ovf`
  - bits 7:4 = `count`, zero-extended
  - all other bits = 0
- DATA read (`rd_en`, `addr=1`):
  - Non-empty: returns bit31 = 1 and bits 12:0 = head entry, then pops (`rptr` wraps, `count` decrements).
  - Empty: returns all zero; no state change.
- STATUS write (`wr_en`, `addr=0`):
  - `wdata[2]=1` clears `ovf`.
  - `wdata[0]=1` flushes the FIFO: `count=0`, `rptr=wptr=0`.
- Writes to DATA are ignored. `rd_en` and `wr_en` asserted together: the write is ignored.
- Simultaneous events:
  - Push + pop with 0<`count`<`DEPTH`: both happen; `count` unchanged.
  - Push + pop when full: the pop frees a slot, so the push is accepted and `ovf` is unchanged.
  - Push + pop when empty: the read returns zero and the push is accepted, leaving `count=1`.
  - Push + flush: flush wins, the push is discarded, and `ovf` is not set.
  - Push + `ovf` clear while full: the dropped push sets `ovf`, and the set wins over the clear.
- Reset:
  - Clears `start_d`, pointers, `count`, `ovf`, `rdata`, `irq` and all storage to 0.
  - Applies mid-burst; no pending push survives.
  - If `start` is already high when reset releases, `start_d=0` makes the first cycle count as an edge and push once.

## Timing
- `rdata` is valid the cycle after the `rd_en` edge and holds until the next read.
- Push latency:
  - `start` sampled 1 at edge N with `start_d=0`: entry stored and `count` updated at edge N.
  - A STATUS read strobed at edge N+1 shows it.
- Pop takes effect at the read edge. A back-to-back DATA read on the next cycle returns the next entry.
- `ovf` sets at the dropping push edge and clears at the store edge.
- Throughput: one push and one pop per cycle.

## Configuration
- `IOQ_IRQ_EN` defined:
  - `irq` is a registered output, equal to `count!=0 | ovf` from the previous edge.
  - Reset value is 0.
  - It falls one cycle after the queue drains and `ovf` is cleared.
- Not defined: the `irq` port does not exist. Software polls STATUS.

## Test plan
- Single press: after reset, `start` high 10 cycles with `{y1,y2,y3,y4}=13'h1A5C`.
  - STATUS reads `count=1`, empty=0.
  - DATA reads `32'h80001A5C`.
  - Next STATUS reads empty=1.
- Overflow, `DEPTH=4`: 5 presses with words 1..5.
  - STATUS = `32'h46` (count 4, full, `ovf`).
  - Four DATA reads return `0x80000001`..`0x80000004`.
  - Fifth DATA read returns 0.
- Wrap-around: 6 push/pop pairs, interleaved.
  - Words `0x0AA`..`0x0AF` read back in order with bit31 set.
  - Pointers wrap with no loss.
- Simultaneous:
  - Push edge coincident with a DATA read at `count=2`: count stays 2 and the data order is preserved.
  - Push coincident with flush: count 0, `ovf` 0.
  - Push coincident with a DATA read when full: push accepted, `ovf` unchanged.
- `ovf` clear and flush:
  - Store `wdata=5` to STATUS: STATUS then reads `32'h01`.
  - Reset asserted mid-press: all outputs 0 next cycle.
  - `start` still high at reset release: exactly one push.
- `IOQ_IRQ_EN` defined:
  - After one press, `irq` rises one cycle after `count` goes non-zero.
  - It falls one cycle after the final DATA pop.
